// File: rtl/accumulator_pkg.sv
// accumulator_pkg
//   Shared constants for the accumulator block. The default widths live here
//   so that every instantiation site and the top-level parameter defaults
//   agree on a single value.
//   No ports (package).
package accumulator_pkg;

   localparam int unsigned ACC_WIDTH_DEFAULT = 32'd26;
   localparam int unsigned CNT_WIDTH_DEFAULT = 32'd16;

endpackage : accumulator_pkg

// File: rtl/acc_sat_add.sv
// acc_sat_add
//   Combinational WIDTH+1-bit adder with carry detect and overflow policy
//   select (wrap or clamp). Holds no state.
//   Ports:
//     acc        in  WIDTH  current running sum
//     increment  in  WIDTH  unsigned addend
//     sum        out WIDTH  next running sum after wrap/clamp
//     carry      out 1      set when acc+increment exceeds 2^WIDTH-1
module acc_sat_add #(
   parameter int WIDTH    = 26,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] increment,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] sum_full_s;

   // Full-width add; the top bit is the carry out of the WIDTH-bit sum.
   always_comb begin
      sum_full_s = {1'b0, acc} + {1'b0, increment};
      carry      = sum_full_s[WIDTH];
      // Clamping only applies on carry; an exact all-ones sum passes through.
      if (carry && (SATURATE != 32'sd0)) begin
         sum = '1;
      end else begin
         sum = sum_full_s[WIDTH-1:0];
      end
   end

endmodule : acc_sat_add

// File: rtl/accumulator.sv
// accumulator
//   Registered running-sum accumulator with sticky overflow flag and a
//   counter of accepted samples.
//   Ports:
//     clk          in  1          clock, rising edge
//     GlobalReset  in  1          asynchronous active-low reset
//     sample       in  1          accumulate strobe
//     increment    in  WIDTH      unsigned addend, taken when sample=1
//     Out          out WIDTH      registered running sum
//     overflow     out 1          sticky, set on any carry until reset
//     count        out CNT_WIDTH  registered accepted-sample count (wraps)
module accumulator
   import accumulator_pkg::*;
#(
   parameter int WIDTH     = ACC_WIDTH_DEFAULT,
   parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT,
   parameter int SATURATE  = 0
) (
   input  logic                 clk,
   input  logic                 GlobalReset,
   input  logic                 sample,
   input  logic [WIDTH-1:0]     increment,
   output logic [WIDTH-1:0]     Out,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] count
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]     out_q, out_d;
   logic                 overflow_q, overflow_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0]     sum_s;
   logic                 carry_s;

   acc_sat_add #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_add (
      .acc       (out_q),
      .increment (increment),
      .sum       (sum_s),
      .carry     (carry_s)
   );

   // Next-state: accept a sample or hold everything.
   always_comb begin
      out_d      = out_q;
      overflow_d = overflow_q;
      count_d    = count_q;
      if (sample) begin
         out_d      = sum_s;
         // Sticky: once set only reset clears it.
         overflow_d = overflow_q | carry_s;
         count_d    = count_q + CNT_ONE;
      end else begin
         out_d      = out_q;
         overflow_d = overflow_q;
         count_d    = count_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         out_q      <= '0;
         overflow_q <= 1'b0;
         count_q    <= '0;
      end else begin
         out_q      <= out_d;
         overflow_q <= overflow_d;
         count_q    <= count_d;
      end
   end

   assign Out      = out_q;
   assign overflow = overflow_q;
   assign count    = count_q;

endmodule : accumulator

// File: tb/tb_accumulator.sv
// tb_accumulator
//   Directed bench for accumulator: one wrapping instance and one
//   saturating instance sharing clock and reset, separate data inputs.
module tb_accumulator;

   localparam int W = 26;
   localparam int C = 16;

   typedef struct packed {
      logic         s;
      logic [W-1:0] inc;
      logic [W-1:0] out;
      logic         ov;
      logic [C-1:0] cnt;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sample_w, sample_s;
   logic [W-1:0] inc_w, inc_s;
   logic [W-1:0] out_w, out_s;
   logic         ov_w, ov_s;
   logic [C-1:0] cnt_w, cnt_s;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   accumulator #(.WIDTH(W), .CNT_WIDTH(C), .SATURATE(0)) u_wrap (
      .clk         (clk),
      .GlobalReset (rst_n),
      .sample      (sample_w),
      .increment   (inc_w),
      .Out         (out_w),
      .overflow    (ov_w),
      .count       (cnt_w)
   );

   accumulator #(.WIDTH(W), .CNT_WIDTH(C), .SATURATE(1)) u_sat (
      .clk         (clk),
      .GlobalReset (rst_n),
      .sample      (sample_s),
      .increment   (inc_s),
      .Out         (out_s),
      .overflow    (ov_s),
      .count       (cnt_s)
   );

   // Reset forces zero immediately and ignores inputs across a clock edge.
   task automatic test_reset();
      rst_n    = 1'b1;
      sample_w = 1'b1;
      inc_w    = 26'h155_5555;
      sample_s = 1'b1;
      inc_s    = 26'h2AA_AAAA;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_w, ov_w, cnt_w} !== {26'h0, 1'b0, 16'h0}) begin
         failures++;
         $display("FAIL reset_async_wrap: got out=%h ov=%b cnt=%h, expected 0/0/0", out_w, ov_w, cnt_w);
      end
      checks++;
      if ({out_s, ov_s, cnt_s} !== {26'h0, 1'b0, 16'h0}) begin
         failures++;
         $display("FAIL reset_async_sat: got out=%h ov=%b cnt=%h, expected 0/0/0", out_s, ov_s, cnt_s);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out_w, ov_w, cnt_w} !== {26'h0, 1'b0, 16'h0}) begin
         failures++;
         $display("FAIL reset_hold_wrap: got out=%h ov=%b cnt=%h, expected 0/0/0", out_w, ov_w, cnt_w);
      end
      checks++;
      if ({out_s, ov_s, cnt_s} !== {26'h0, 1'b0, 16'h0}) begin
         failures++;
         $display("FAIL reset_hold_sat: got out=%h ov=%b cnt=%h, expected 0/0/0", out_s, ov_s, cnt_s);
      end
      sample_w = 1'b0;
      sample_s = 1'b0;
      inc_w    = 26'h0;
      inc_s    = 26'h0;
      rst_n    = 1'b1;
   endtask

   // Single pulses followed by idle cycles; values must hold while idle.
   task automatic test_single_pulse();
      vec_t v [10];
      v[0] = '{1'b1, 26'd1, 26'd1, 1'b0, 16'd1};
      for (int i = 1; i < 5; i++) v[i] = '{1'b0, 26'd0, 26'd1, 1'b0, 16'd1};
      v[5] = '{1'b1, 26'd2, 26'd3, 1'b0, 16'd2};
      for (int i = 6; i < 10; i++) v[i] = '{1'b0, 26'd0, 26'd3, 1'b0, 16'd2};
      for (int i = 0; i < 10; i++) begin
         sample_w = v[i].s;
         inc_w    = v[i].inc;
         @(posedge clk);
         #1;
         checks++;
         if ({out_w, ov_w, cnt_w} !== {v[i].out, v[i].ov, v[i].cnt}) begin
            failures++;
            $display("FAIL single_pulse[%0d]: got out=%h ov=%b cnt=%0d, expected out=%h ov=%b cnt=%0d",
                     i, out_w, ov_w, cnt_w, v[i].out, v[i].ov, v[i].cnt);
         end
      end
      sample_w = 1'b0;
   endtask

   // Wrap policy: exact all-ones is not overflow, carry wraps and sticks.
   task automatic test_wrap();
      vec_t v [5];
      v[0] = '{1'b1, 26'h3FF_FFFC, 26'h3FF_FFFF, 1'b0, 16'd3};
      v[1] = '{1'b1, 26'h000_0001, 26'h000_0000, 1'b1, 16'd4};
      v[2] = '{1'b1, 26'h000_0005, 26'h000_0005, 1'b1, 16'd5};
      v[3] = '{1'b0, 26'h000_0000, 26'h000_0005, 1'b1, 16'd5};
      v[4] = '{1'b1, 26'h000_0000, 26'h000_0005, 1'b1, 16'd6};
      for (int i = 0; i < 5; i++) begin
         sample_w = v[i].s;
         inc_w    = v[i].inc;
         @(posedge clk);
         #1;
         checks++;
         if ({out_w, ov_w, cnt_w} !== {v[i].out, v[i].ov, v[i].cnt}) begin
            failures++;
            $display("FAIL wrap[%0d]: got out=%h ov=%b cnt=%0d, expected out=%h ov=%b cnt=%0d",
                     i, out_w, ov_w, cnt_w, v[i].out, v[i].ov, v[i].cnt);
         end
      end
      sample_w = 1'b0;
   endtask

   // Saturate policy: clamp at all-ones and stay there.
   task automatic test_saturate();
      vec_t v [6];
      v[0] = '{1'b1, 26'h3FF_FFFD, 26'h3FF_FFFD, 1'b0, 16'd1};
      v[1] = '{1'b1, 26'h000_0001, 26'h3FF_FFFE, 1'b0, 16'd2};
      v[2] = '{1'b1, 26'h000_0003, 26'h3FF_FFFF, 1'b1, 16'd3};
      v[3] = '{1'b1, 26'h000_0007, 26'h3FF_FFFF, 1'b1, 16'd4};
      v[4] = '{1'b0, 26'h000_0000, 26'h3FF_FFFF, 1'b1, 16'd4};
      v[5] = '{1'b1, 26'h000_0000, 26'h3FF_FFFF, 1'b1, 16'd5};
      for (int i = 0; i < 6; i++) begin
         sample_s = v[i].s;
         inc_s    = v[i].inc;
         @(posedge clk);
         #1;
         checks++;
         if ({out_s, ov_s, cnt_s} !== {v[i].out, v[i].ov, v[i].cnt}) begin
            failures++;
            $display("FAIL saturate[%0d]: got out=%h ov=%b cnt=%0d, expected out=%h ov=%b cnt=%0d",
                     i, out_s, ov_s, cnt_s, v[i].out, v[i].ov, v[i].cnt);
         end
      end
      sample_s = 1'b0;
   endtask

   // Sample held high, then reset between edges, then restart from zero.
   task automatic test_back_to_back();
      logic [W-1:0] exp_out;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      checks++;
      if ({out_s, ov_s, cnt_s} !== {26'h0, 1'b0, 16'h0}) begin
         failures++;
         $display("FAIL pre_b2b_reset_sat: got out=%h ov=%b cnt=%h, expected 0/0/0", out_s, ov_s, cnt_s);
      end
      sample_w = 1'b1;
      inc_w    = 26'd4;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         exp_out = W'(4 * i);
         checks++;
         if ({out_w, ov_w, cnt_w} !== {exp_out, 1'b0, C'(i)}) begin
            failures++;
            $display("FAIL b2b[%0d]: got out=%h ov=%b cnt=%0d, expected out=%h ov=0 cnt=%0d",
                     i, out_w, ov_w, cnt_w, exp_out, i);
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_w, ov_w, cnt_w} !== {26'h0, 1'b0, 16'h0}) begin
         failures++;
         $display("FAIL reset_mid: got out=%h ov=%b cnt=%h, expected 0/0/0", out_w, ov_w, cnt_w);
      end
      rst_n = 1'b1;
      inc_w = 26'd9;
      @(posedge clk);
      #1;
      checks++;
      if ({out_w, ov_w, cnt_w} !== {26'd9, 1'b0, 16'd1}) begin
         failures++;
         $display("FAIL post_reset_first: got out=%h ov=%b cnt=%0d, expected out=9 ov=0 cnt=1", out_w, ov_w, cnt_w);
      end
      sample_w = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_wrap();
      test_saturate();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_accumulator
